// File: rtl/multdiv_unit_if.sv
// Request/response bundle between the execute-stage latch and multdiv_unit.
// The master drives operands, start pulses and the destination tag.
// The slave (the unit) returns the result, exception flag, tag, ready and busy.
interface multdiv_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [TAG_W-1:0] tag_in;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic [TAG_W-1:0] tag_out;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, tag_in,
        input  data_result, data_exception, data_resultRDY, tag_out, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, tag_in,
        output data_result, data_exception, data_resultRDY, tag_out, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide unit for the execute stage.
// Multiply: radix-4 Booth, one digit per cycle, WIDTH/2 iterations.
// Divide: restoring shift-subtract on magnitudes, one quotient bit per cycle.
// Optional macro MULTDIV_EARLY_DIV0_EN: divide-by-zero finishes after one
// cycle instead of running the full WIDTH iterations.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_unit_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(WIDTH / 2);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(WIDTH);

`ifdef MULTDIV_EARLY_DIV0_EN
    localparam bit EARLY_DIV0 = 1'b1;
`else
    localparam bit EARLY_DIV0 = 1'b0;
`endif

    logic [1:0]         state_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [2*WIDTH:0]   prod_reg;      // {acc[WIDTH-1:0], multiplier[WIDTH-1:0], guard}
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quo_reg;       // dividend shifts out the top, quotient shifts in
    logic [WIDTH-1:0]   divisor_reg;
    logic               qsign_reg;
    logic               div0_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               exc_reg;
    logic               rdy_reg;
    logic [TAG_W-1:0]   tag_out_reg;

    logic [WIDTH+1:0]   acc_ext;
    logic [WIDTH+1:0]   m_ext;
    logic [WIDTH+1:0]   m2_ext;
    logic [WIDTH+1:0]   booth_sum;
    logic [2*WIDTH:0]   prod_next;
    logic [2*WIDTH-1:0] product;
    logic               mult_ovf;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               mult_finish;
    logic               div_finish;

    // Booth step: the accumulator is widened by two bits so adding +/-2M cannot
    // wrap; after the 2-bit arithmetic shift it fits back into WIDTH bits.
    always_comb begin
        acc_ext   = {{2{prod_reg[2*WIDTH]}}, prod_reg[2*WIDTH:WIDTH+1]};
        m_ext     = {{2{mcand_reg[WIDTH-1]}}, mcand_reg};
        m2_ext    = {mcand_reg[WIDTH-1], mcand_reg, 1'b0};
        booth_sum = acc_ext;
        case (prod_reg[2:0])
            3'b001, 3'b010: booth_sum = acc_ext + m_ext;
            3'b011:         booth_sum = acc_ext + m2_ext;
            3'b100:         booth_sum = acc_ext - m2_ext;
            3'b101, 3'b110: booth_sum = acc_ext - m_ext;
            default:        booth_sum = acc_ext;
        endcase
        prod_next = {booth_sum, prod_reg[WIDTH:2]};
        product   = prod_reg[2*WIDTH:1];
        // Signed overflow when the top WIDTH+1 product bits are not a pure sign run.
        mult_ovf  = !((&product[2*WIDTH-1:WIDTH-1]) || ~(|product[2*WIDTH-1:WIDTH-1]));
    end

    // Restoring divide step on unsigned magnitudes; the remainder stays below
    // the divisor, so WIDTH bits hold it between steps.
    always_comb begin
        rem_shift = {rem_reg, quo_reg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, divisor_reg};
        if (!rem_diff[WIDTH]) begin
            rem_next = rem_diff[WIDTH-1:0];
            quo_next = {quo_reg[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[WIDTH-1:0];
            quo_next = {quo_reg[WIDTH-2:0], 1'b0};
        end
    end

    // Operand magnitudes and iteration-complete conditions.
    always_comb begin
        abs_a       = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
        abs_b       = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
        mult_finish = (count_reg == MULT_LAST);
        div_finish  = (count_reg == DIV_LAST) || (EARLY_DIV0 && div0_reg);
    end

    // Control FSM, datapath registers and the held output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            prod_reg    <= '0;
            mcand_reg   <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            qsign_reg   <= 1'b0;
            div0_reg    <= 1'b0;
            tag_reg     <= '0;
            result_reg  <= '0;
            exc_reg     <= 1'b0;
            rdy_reg     <= 1'b0;
            tag_out_reg <= '0;
        end else begin
            rdy_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    count_reg <= '0;
                    if (bus.ctrl_MULT) begin
                        mcand_reg <= bus.data_operandA;
                        prod_reg  <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
                        tag_reg   <= bus.tag_in;
                        state_reg <= S_MULT;
                    end else if (bus.ctrl_DIV) begin
                        quo_reg     <= abs_a;
                        divisor_reg <= abs_b;
                        rem_reg     <= '0;
                        qsign_reg   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                        div0_reg    <= (bus.data_operandB == '0);
                        tag_reg     <= bus.tag_in;
                        state_reg   <= S_DIV;
                    end
                end
                S_MULT: begin
                    if (mult_finish) begin
                        result_reg  <= product[WIDTH-1:0];
                        exc_reg     <= mult_ovf;
                        tag_out_reg <= tag_reg;
                        rdy_reg     <= 1'b1;
                        state_reg   <= S_DONE;
                    end else begin
                        prod_reg  <= prod_next;
                        count_reg <= count_reg + 1'b1;
                    end
                end
                S_DIV: begin
                    if (div_finish) begin
                        if (div0_reg) begin
                            result_reg <= '0;
                            exc_reg    <= 1'b1;
                        end else begin
                            result_reg <= qsign_reg ? -quo_reg : quo_reg;
                            // Only MIN / -1 yields a positive quotient of 2^(WIDTH-1).
                            exc_reg    <= ~qsign_reg & quo_reg[WIDTH-1];
                        end
                        tag_out_reg <= tag_reg;
                        rdy_reg     <= 1'b1;
                        state_reg   <= S_DONE;
                    end else begin
                        rem_reg   <= rem_next;
                        quo_reg   <= quo_next;
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_result    = result_reg;
    assign bus.data_exception = exc_reg;
    assign bus.data_resultRDY = rdy_reg;
    assign bus.tag_out        = tag_out_reg;
    assign bus.busy           = (state_reg == S_MULT) || (state_reg == S_DIV);

endmodule
